// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: control codes, status bit
// positions and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] CTRL_AND   = 4'd0;
  localparam logic [3:0] CTRL_OR    = 4'd1;
  localparam logic [3:0] CTRL_ADD   = 4'd2;
  localparam logic [3:0] CTRL_DIV   = 4'd4;
  localparam logic [3:0] CTRL_MUL   = 4'd5;
  localparam logic [3:0] CTRL_SUB   = 4'd6;
  localparam logic [3:0] CTRL_SLT   = 4'd7;
  localparam logic [3:0] CTRL_SLL   = 4'd8;
  localparam logic [3:0] CTRL_SRL   = 4'd9;
  localparam logic [3:0] CTRL_XOR   = 4'd10;
  localparam logic [3:0] CTRL_NOR   = 4'd11;
  localparam logic [3:0] CTRL_ADDR0 = 4'd12;
  localparam logic [3:0] CTRL_ADDR1 = 4'd13;

  localparam int ST_ZERO   = 7;
  localparam int ST_MULOVF = 6;
  localparam int ST_CARRY  = 5;
  localparam int ST_NEG    = 4;
  localparam int ST_MISAL  = 3;
  localparam int ST_DIVZ   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arb_alu.sv
// Purely combinational 32-bit ALU; produces the result and the 8-bit
// status vector for one captured operation.
module alu_arb_alu
  import alu_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [7:0]  status
);

  logic [32:0] sum_s;
  logic [32:0] diff_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic        carry_s;
  logic        ovf_s;
  logic        divz_s;
  logic        misal_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};
  // Sign-extended operands make the low 64 bits equal the signed product
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Signed divide with the zero divisor and MIN/-1 corners pinned
  always_comb begin
    quot_s = 32'd0;
    if (b == 32'd0) begin
      quot_s = 32'd0;
    end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      quot_s = 32'h8000_0000;
    end else begin
      quot_s = $signed(a) / $signed(b);
    end
  end

  // Operation select and status assembly
  always_comb begin
    result  = 32'd0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    divz_s  = 1'b0;
    misal_s = 1'b0;
    case (ctrl)
      CTRL_AND: result = a & b;
      CTRL_OR:  result = a | b;
      CTRL_ADD: begin
        result  = sum_s[31:0];
        carry_s = sum_s[32];
      end
      CTRL_DIV: begin
        result = quot_s;
        divz_s = (b == 32'd0);
      end
      CTRL_MUL: begin
        result = prod_s[31:0];
        ovf_s  = (prod_s[63:32] != 32'd0);
      end
      CTRL_SUB: begin
        result  = diff_s[31:0];
        carry_s = diff_s[32];
      end
      CTRL_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      CTRL_SLL: result = a << b[4:0];
      CTRL_SRL: result = a >> b[4:0];
      CTRL_XOR: result = a ^ b;
      CTRL_NOR: result = ~(a | b);
      CTRL_ADDR0, CTRL_ADDR1: begin
        result  = sum_s[31:0];
        misal_s = (sum_s[1:0] != 2'd0);
      end
      default: result = 32'd0;
    endcase
    status            = 8'd0;
    status[ST_ZERO]   = (result == 32'd0);
    status[ST_MULOVF] = ovf_s;
    status[ST_CARRY]  = carry_s;
    status[ST_NEG]    = result[31];
    status[ST_MISAL]  = misal_s;
    status[ST_DIVZ]   = divz_s;
  end

endmodule

// File: rtl/alu_arb.sv
// Two-requester front end sharing one ALU: arbitration, capture registers,
// IDLE/EXEC/RESP sequencer and a saturating exception counter.
module alu_arb
  import alu_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic [7:0]       rsp_status,
  output logic [CNT_W-1:0] exc_cnt
);

  state_t      state_r;
  logic        last_grant_r;
  logic [3:0]  op_ctrl_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic        op_id_r;

  logic        grant0_s;
  logic        grant1_s;
  logic        accept_s;
  logic        exc_s;
  logic [31:0] alu_result_s;
  logic [7:0]  alu_status_s;

  // Grant selection; last_grant_r = 1 means requester 1 won the previous accept
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      if (RR_EN) begin
        grant0_s = last_grant_r;
        grant1_s = ~last_grant_r;
      end else begin
        grant0_s = 1'b1;
      end
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Reset gates the readies so they drop in the same cycle rst_n falls
  assign req0_ready = rst_n & (state_r == IDLE) & grant0_s;
  assign req1_ready = rst_n & (state_r == IDLE) & grant1_s;
  assign accept_s   = req0_ready | req1_ready;
  assign exc_s      = rsp_status[ST_MULOVF] | rsp_status[ST_DIVZ];

  alu_arb_alu u_alu (
    .ctrl   (op_ctrl_r),
    .a      (op_a_r),
    .b      (op_b_r),
    .result (alu_result_s),
    .status (alu_status_s)
  );

  // Sequencer with capture registers, response registers and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      op_ctrl_r    <= 4'd0;
      op_a_r       <= 32'd0;
      op_b_r       <= 32'd0;
      op_id_r      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 32'd0;
      rsp_status   <= 8'd0;
      exc_cnt      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_id_r      <= req1_ready;
            op_ctrl_r    <= req1_ready ? req1_ctrl : req0_ctrl;
            op_a_r       <= req1_ready ? req1_a    : req0_a;
            op_b_r       <= req1_ready ? req1_b    : req0_b;
            last_grant_r <= req1_ready;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result_s;
          rsp_status <= alu_status_s;
          rsp_id     <= op_id_r;
          rsp_valid  <= 1'b1;
          state_r    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
            if (exc_s && (exc_cnt != {CNT_W{1'b1}})) begin
              exc_cnt <= exc_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter CNT_W, 16, width of the saturating exception counter.
REQ-002 Parameter RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 reqN_valid  input  1  requester N (N = 0,1) presents an operation.
REQ-006 reqN_ready  output  1  operation of requester N accepted this cycle.
REQ-007 reqN_ctrl  input  4  ALU control code for requester N.
REQ-008 reqN_a, reqN_b  input  32  signed operands for requester N.
REQ-009 rsp_valid  output  1  a response is presented.
REQ-010 rsp_ready  input  1  the consumer takes the response.
REQ-011 rsp_id  output  1  requester that owns the response.
REQ-012 rsp_result  output  32  ALU result.
REQ-013 rsp_status  output  8  ALU status flags:
- bit7 zero
- bit6 mul overflow
- bit5 carry
- bit4 negative
- bit3 misaligned
- bit2 divide-by-zero
- bits1:0 always 0
REQ-014 exc_cnt  output  CNT_W  count of responses that had bit6 or bit2 set.

Function
REQ-015 The block SHALL share one combinational ALU between two requesters through the states IDLE, EXEC and RESP.
REQ-016 The IDLE state SHALL behave as follows:
- reqN_ready = grant_N & reqN_valid, combinational.
- An accept SHALL capture ctrl, a, b and the id into registers, then go to EXEC.
REQ-017 The ALU SHALL see only the captured registers, never live request inputs.
REQ-018 EXEC SHALL last exactly one cycle; result and status are registered at its end, then the state goes to RESP.
REQ-019 RESP SHALL assert rsp_valid, with result, status and id held stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-020 Latency SHALL be fixed: accept in cycle N gives rsp_valid in cycle N+2; peak throughput is one operation per 3 cycles.
REQ-021 Both reqN_ready SHALL be 0 outside IDLE; requests arriving in EXEC/RESP wait, and requesters must hold valid and payload stable until ready.
REQ-022 Arbitration SHALL follow these rules:
- Single valid: that requester is granted.
- Both valid with RR_EN=1: the requester not granted last is granted.
- Both valid with RR_EN=0: requester 0 is granted.
- last_grant SHALL update only on accept.
REQ-023 Control codes SHALL map as follows:
- 0 and, 1 or, 2 add, 4 div, 5 mul, 6 sub, 7 slt
- 8 sll, 9 srl, 10 xor, 11 nor, 12/13 address add
- 3, 14 and 15 are illegal and SHALL give result 0 and status 0x80.
REQ-024 Arithmetic SHALL be 32-bit two's complement, with these rules:
- add/sub carry = bit 32 of the 33-bit sum.
- mul overflow = upper 32 bits of the 64-bit product nonzero.
- div by 0 gives result 0 and bit2 = 1.
- codes 12/13 set bit3 when result[1:0] != 0.
REQ-025 exc_cnt SHALL increment by 1 on each response handshake whose status has bit6 or bit2 set, and saturate at all-ones with no wrap.
REQ-026 A response handshake and a new request SHALL NOT overlap, because a request is accepted only in the cycle after the return to IDLE.

Reset
REQ-027 When rst_n is low, the following SHALL be forced immediately:
- state = IDLE, last_grant = 1
- rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_status = 0
- exc_cnt = 0, both reqN_ready = 0
REQ-028 A reset during EXEC or RESP SHALL discard the operation; no response appears after rst_n is released.

Structure
REQ-029 The shared package alu_pkg SHALL hold:
- the control-code constants
- the status-bit index constants
- the state enumeration (IDLE, EXEC, RESP).
REQ-030 The existing ALU block SHALL be instantiated once as the only sub-module; arbitration, the FSM and the counter stay in alu_arb.

Verification
REQ-031 The bench SHALL check each of the following scenarios:
- Add overflow: req0 ctrl=2, a=0x7FFFFFFF, b=1 accepted in cycle N -> cycle N+2: rsp_valid=1, rsp_id=0, result=0x80000000, status=0x10.
- Arbitration, RR_EN=1: both requesters continuously valid after reset with rsp_ready=1 -> grant order 0,1,0,1.
- Arbitration, RR_EN=0: same stimulus -> grant order 0,0,0.
- Divide by zero: req1 ctrl=4, a=10, b=0 -> result=0, status=0x84, exc_cnt=1.
- Multiply overflow: ctrl=5, a=0x00010000, b=0x00010000 -> result=0, status=0xC0, exc_cnt increments.
- Back-pressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, reqN_ready=0 throughout, handshake completes on the first rsp_ready=1.
- Reset in EXEC: rst_n pulsed low during EXEC -> all outputs 0 the same cycle, and no rsp_valid within 10 cycles with no new request.
- Counter saturation: CNT_W=2 with 5 div-by-zero ops -> exc_cnt=3.
